// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator command sequencer:
// status codes, key codes and the sequencer state encoding.
package calc_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_IDLE  = 2'b11;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_BS  = 4'd15;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_FAULT = 2'd3
    } seq_state_t;

    // The calculator streams display digits while busy and while reporting an error.
    function automatic logic is_capture_status(input logic [1:0] status);
        return (status == ST_ERR) || (status == ST_BUSY);
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous 4-bit key-command FIFO with flush; DEPTH must be a power of two.
// A push and pop in the same cycle both take effect; flush overrides both.
module calc_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [3:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_W);
    assign empty = (count == '0);

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Queues key codes and issues them one at a time to the calculator, and mirrors
// the calculator's digit stream onto an 8-digit display. Timeout: CALC_SEQ_TIMEOUT_EN.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    input  logic [1:0]  calc_status,
    input  logic [3:0]  calc_data,
    input  logic [3:0]  calc_pos,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    output logic [31:0] disp_digits,
    output logic        disp_update,
    output logic [1:0]  seq_state,
    output logic        fault
);

    seq_state_t  state_r;
    seq_state_t  state_nx;
    logic        guard_r;
    logic        timeout_hit;
    logic [3:0]  cmd_r;
    logic [3:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_flush;
    logic [31:0] shadow_r;
    logic [31:0] shadow_nx;
    logic [31:0] disp_r;
    logic        disp_update_r;
    logic        capture;

    // Handshake: a key is accepted exactly when key_valid && key_ready at a rising edge.
    assign key_ready  = !fifo_full && (state_r != SEQ_FAULT);
    assign fifo_push  = key_valid && key_ready;
    assign fifo_pop   = (state_r == SEQ_ISSUE);
    assign fifo_flush = (state_nx == SEQ_FAULT);

    calc_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(key_code),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef CALC_SEQ_TIMEOUT_EN
    logic [9:0] wait_cnt_r;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r != SEQ_WAIT) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 10'd1;
        end
    end

    assign timeout_hit = (state_r == SEQ_WAIT) && (wait_cnt_r == 10'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= SEQ_IDLE;
            guard_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            guard_r <= (state_r == SEQ_ISSUE);
        end
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            SEQ_IDLE: begin
                if (!fifo_empty && calc_status == ST_READY) begin
                    state_nx = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                state_nx = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                // The first WAIT cycle ignores status: the calculator has not yet reacted.
                if (!guard_r && calc_status == ST_ERR) begin
                    state_nx = SEQ_FAULT;
                end else if (!guard_r && calc_status == ST_READY) begin
                    state_nx = SEQ_IDLE;
                end else if (timeout_hit) begin
                    state_nx = SEQ_FAULT;
                end
            end
            SEQ_FAULT: begin
                state_nx = SEQ_FAULT;
            end
            default: begin
                state_nx = SEQ_IDLE;
            end
        endcase
    end

    // The head is latched on the way into ISSUE, so cmd is a plain register that
    // shows the command during ISSUE and keeps it afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_r <= '0;
        end else if (state_r == SEQ_IDLE && state_nx == SEQ_ISSUE) begin
            cmd_r <= fifo_head;
        end
    end

    assign capture = is_capture_status(calc_status) && (calc_pos <= 4'd7);

    always_comb begin
        shadow_nx = shadow_r;
        if (capture) begin
            shadow_nx[{calc_pos[2:0], 2'b00} +: 4] = calc_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_r      <= '0;
            disp_r        <= '0;
            disp_update_r <= 1'b0;
        end else begin
            shadow_r      <= shadow_nx;
            disp_update_r <= capture && (calc_pos == 4'd7);
            if (capture && calc_pos == 4'd7) begin
                disp_r <= shadow_nx;
            end
        end
    end

    assign cmd         = cmd_r;
    assign cmd_valid   = (state_r == SEQ_ISSUE);
    assign disp_digits = disp_r;
    assign disp_update = disp_update_r;
    assign seq_state   = state_r;
    assign fault       = (state_r == SEQ_FAULT);

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer: key ordering, FIFO full, display
// capture, error fault, timeout (CALC_SEQ_TIMEOUT_EN aware) and reset mid-WAIT.
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int TMO        = 8;

    logic        clock;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [1:0]  calc_status;
    logic [3:0]  calc_data;
    logic [3:0]  calc_pos;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic [31:0] disp_digits;
    logic        disp_update;
    logic [1:0]  seq_state;
    logic        fault;

    int          n_checks;
    int          n_fail;
    logic [3:0]  exp_q[$];

    calc_cmd_sequencer #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .calc_status(calc_status),
        .calc_data  (calc_data),
        .calc_pos   (calc_pos),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .disp_digits(disp_digits),
        .disp_update(disp_update),
        .seq_state  (seq_state),
        .fault      (fault)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'd0;
        calc_status = ST_IDLE;
        calc_data   = 4'd0;
        calc_pos    = 4'hF;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Driver tasks
    task automatic push_key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic wait_issue(input int budget);
        for (int c = 0; c < budget && !cmd_valid; c++) @(negedge clock);
        check("issue_seen", 32'(cmd_valid), 32'd1);
    endtask

    // Answers busy in the ISSUE cycle and ready from the next cycle on.
    task automatic run_cmds(input int n_exp, input int budget);
        int got  = 0;
        int last = -100;
        for (int c = 0; c < budget; c++) begin
            if (cmd_valid) begin
                got++;
                if (exp_q.size() > 0) check("cmd_value", 32'(cmd), 32'(exp_q.pop_front()));
                if (got > 1) check("cmd_spacing_ge3", 32'(c - last >= 3), 32'd1);
                last = c;
                calc_status = ST_BUSY;
            end else begin
                calc_status = ST_READY;
            end
            @(negedge clock);
        end
        check("cmd_count", 32'(got), 32'(n_exp));
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_cmd"}, 32'(cmd), 32'd0);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_disp"}, disp_digits, 32'd0);
        check({tag, "_disp_update"}, 32'(disp_update), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_key_ready"}, 32'(key_ready), 32'd1);
        check({tag, "_state"}, 32'(seq_state), 32'd0);
    endtask

    initial begin
        logic [3:0] pat1 [8];
        int         n_cmd;
        n_checks = 0;
        n_fail   = 0;
        pat1     = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

        // Reset state
        apply_reset();
        expect_reset_outputs("reset");

        // Ordered issue of 3, +, 4, =
        push_key(4'd3);
        push_key(KEY_ADD);
        push_key(4'd4);
        push_key(KEY_EQ);
        check("order_full_key_ready", 32'(key_ready), 32'd0);
        check("order_no_issue_when_idle", 32'(cmd_valid), 32'd0);
        exp_q = {4'd3, KEY_ADD, 4'd4, KEY_EQ};
        run_cmds(4, 30);
        check("order_cmd_hold", 32'(cmd), 32'(KEY_EQ));
        check("order_cmd_valid_low", 32'(cmd_valid), 32'd0);
        check("order_back_idle", 32'(seq_state), 32'd0);

        // Five pushes while busy: fifth dropped
        apply_reset();
        calc_status = ST_BUSY;
        for (int i = 0; i < 5; i++) begin
            check("full_key_ready", 32'(key_ready), 32'(i < 4));
            check("full_no_cmd", 32'(cmd_valid), 32'd0);
            push_key(4'(i + 1));
        end
        check("full_key_ready_after", 32'(key_ready), 32'd0);
        exp_q = {4'd1, 4'd2, 4'd3, 4'd4};
        run_cmds(4, 30);

        // Display capture
        apply_reset();
        calc_status = ST_BUSY;
        for (int p = 0; p < 8; p++) begin
            calc_pos  = 4'(p);
            calc_data = pat1[p];
            check("disp_update_quiet", 32'(disp_update), 32'd0);
            @(negedge clock);
        end
        calc_status = ST_IDLE;
        calc_pos    = 4'hF;
        check("disp_update_pulse", 32'(disp_update), 32'd1);
        check("disp_value_7", disp_digits, 32'h0000_0007);
        @(negedge clock);
        check("disp_update_once", 32'(disp_update), 32'd0);
        check("disp_value_hold", disp_digits, 32'h0000_0007);
        calc_status = ST_BUSY;
        calc_pos    = 4'd9;
        calc_data   = 4'hF;
        @(negedge clock);
        for (int p = 0; p < 8; p++) begin
            calc_pos  = 4'(p);
            calc_data = 4'(p + 1);
            @(negedge clock);
        end
        calc_status = ST_READY;
        calc_pos    = 4'd3;
        calc_data   = 4'd0;
        check("disp_value_seq", disp_digits, 32'h8765_4321);
        @(negedge clock);
        calc_pos = 4'hF;
        @(negedge clock);
        check("disp_no_capture_ready", disp_digits, 32'h8765_4321);
        check("disp_update_ready_quiet", 32'(disp_update), 32'd0);

        // Error status in WAIT
        apply_reset();
        push_key(4'd5);
        push_key(4'd6);
        calc_status = ST_READY;
        wait_issue(10);
        check("fault_first_cmd", 32'(cmd), 32'd5);
        calc_status = ST_BUSY;
        @(negedge clock);
        check("fault_guard_state", 32'(seq_state), 32'd2);
        calc_status = ST_ERR;
        @(negedge clock);
        check("fault_guard_ignores_err", 32'(seq_state), 32'd2);
        @(negedge clock);
        check("fault_state", 32'(seq_state), 32'd3);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_key_ready", 32'(key_ready), 32'd0);
        check("fault_cmd_valid", 32'(cmd_valid), 32'd0);
        calc_status = ST_READY;
        key_valid   = 1'b1;
        key_code    = 4'd7;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("fault_hold_state", 32'(seq_state), 32'd3);
            check("fault_hold_ready", 32'(key_ready), 32'd0);
            check("fault_hold_cmd_valid", 32'(cmd_valid), 32'd0);
        end
        key_valid   = 1'b0;
        calc_status = ST_ERR;
        for (int p = 0; p < 8; p++) begin
            calc_pos  = 4'(p);
            calc_data = (p == 1) ? 4'hE : 4'h0;
            @(negedge clock);
        end
        calc_pos = 4'hF;
        check("fault_disp_capture", disp_digits, 32'h0000_00E0);
        check("fault_disp_update", 32'(disp_update), 32'd1);
        check("fault_still_fault", 32'(fault), 32'd1);
        apply_reset();
        check("fault_cleared_state", 32'(seq_state), 32'd0);
        check("fault_cleared_flag", 32'(fault), 32'd0);
        check("fault_cleared_ready", 32'(key_ready), 32'd1);

        // Timeout with status stuck busy
        apply_reset();
        push_key(4'd9);
        calc_status = ST_READY;
        wait_issue(10);
        calc_status = ST_BUSY;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            check("tmo_in_wait", 32'(seq_state), 32'd2);
        end
        @(negedge clock);
`ifdef CALC_SEQ_TIMEOUT_EN
        check("tmo_fault", 32'(seq_state), 32'd3);
        repeat (20) @(negedge clock);
        check("tmo_fault_hold", 32'(fault), 32'd1);
`else
        check("tmo_no_fault", 32'(seq_state), 32'd2);
        repeat (20) @(negedge clock);
        check("tmo_still_wait", 32'(seq_state), 32'd2);
`endif

        // Reset mid-WAIT with entries queued
        apply_reset();
        calc_status = ST_BUSY;
        calc_pos    = 4'd7;
        calc_data   = 4'd5;
        @(negedge clock);
        calc_pos = 4'hF;
        check("rst_disp_before", disp_digits, 32'h5000_0000);
        calc_status = ST_IDLE;
        push_key(4'd1);
        push_key(4'd2);
        push_key(4'd3);
        calc_status = ST_READY;
        wait_issue(10);
        calc_status = ST_BUSY;
        repeat (2) @(negedge clock);
        check("rst_in_wait", 32'(seq_state), 32'd2);
        #2 reset = 1'b1;
        #1 expect_reset_outputs("rst_async");
        @(negedge clock);
        reset       = 1'b0;
        calc_status = ST_READY;
        n_cmd       = 0;
        for (int c = 0; c < 12; c++) begin
            if (cmd_valid) n_cmd++;
            @(negedge clock);
        end
        check("rst_queue_discarded", 32'(n_cmd), 32'd0);
        check("rst_state_idle", 32'(seq_state), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
